lisa_lsu: RTL

LISA_LSU -- requirements
Module: lisa_lsu

---
 rtl/lisa_lsu_if.sv | 32 +++
 rtl/lisa_lsu.sv | 129 ++++++++++++
 2 files changed

// File: rtl/lisa_lsu_if.sv
// Core-side request/response and data-memory signals of the LISA load/store unit.
// master = core + memory side, slave = LSU.
interface lisa_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [15:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
      input  mem_addr, mem_write_en, mem_write_data,
      output mem_read_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_fault,
      output mem_addr, mem_write_en, mem_write_data,
      input  mem_read_data
   );
endinterface

// File: rtl/lisa_lsu.sv
// Byte/halfword/word load-store unit; accept-to-response 1 (fault), 2 (load, word store), 3 (sub-word store) cycles.
// One request in flight: req_ready only in IDLE; the response pulse is never backpressured.
module lisa_lsu #(
   parameter int MEM_BYTES = 1024
) (
   input logic       clk,
   input logic       rst_n,
   lisa_lsu_if.slave bus
);

   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic        w_fault;
   logic [16:0] w_nbytes;
   logic [16:0] w_end;
   logic [31:0] w_load_data;

   logic        r_write;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [15:0] r_addr;
   logic [31:0] r_merge;
   logic [31:0] r_rdata;
   logic        r_fault;

   // Range check is done in 17 bits so an access ending exactly at 64 KiB does not wrap.
   always_comb begin
      w_nbytes = 17'd1;
      case (bus.req_size)
         2'b01:   w_nbytes = 17'd2;
         2'b10:   w_nbytes = 17'd4;
         default: w_nbytes = 17'd1;
      endcase
      w_end   = {1'b0, bus.req_addr} + w_nbytes;
      w_fault = (bus.req_size == 2'b11)
              | ((bus.req_size == 2'b01) & bus.req_addr[0])
              | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
              | (w_end > 17'(MEM_BYTES));
   end

   always_comb begin
      w_load_data = bus.mem_read_data;
      case (r_size)
         2'b00:   w_load_data = {{24{r_signed & bus.mem_read_data[7]}},  bus.mem_read_data[7:0]};
         2'b01:   w_load_data = {{16{r_signed & bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
         default: w_load_data = bus.mem_read_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req_valid) begin
               w_accept = 1'b1;
               if (w_fault)                   w_next = RESP;
               else if (!bus.req_write)       w_next = LOAD;
               else if (bus.req_size == 2'b10) w_next = WRITE;
               else                           w_next = MERGE;
            end
         end
         LOAD:    w_next = RESP;
         MERGE:   w_next = WRITE;
         WRITE:   w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Response registers only change on entry to RESP so they stay stable between responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_write  <= 1'b0;
         r_size   <= 2'b00;
         r_signed <= 1'b0;
         r_addr   <= 16'h0000;
         r_merge  <= 32'h0;
         r_rdata  <= 32'h0;
         r_fault  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_write  <= bus.req_write;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_merge  <= bus.req_wdata;
         end
         case (r_state)
            IDLE: begin
               if (w_accept && w_fault) begin
                  r_rdata <= 32'h0;
                  r_fault <= 1'b1;
               end
            end
            LOAD: begin
               r_rdata <= w_load_data;
               r_fault <= 1'b0;
            end
            MERGE: begin
               if (r_size == 2'b00) r_merge <= {bus.mem_read_data[31:8],  r_merge[7:0]};
               else                 r_merge <= {bus.mem_read_data[31:16], r_merge[15:0]};
            end
            WRITE: begin
               r_rdata <= 32'h0;
               r_fault <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready      = (r_state == IDLE);
   assign bus.resp_valid     = (r_state == RESP);
   assign bus.resp_rdata     = r_rdata;
   assign bus.resp_fault     = r_fault;
   assign bus.mem_addr       = r_addr;
   assign bus.mem_write_en   = (r_state == WRITE) & r_write;
   assign bus.mem_write_data = r_merge;

endmodule
